// File: rtl/eq_band_scheduler_pkg.sv
// Shared types and defaults for the equalizer band gain scheduler.
package eq_pkg;

    localparam int DEF_N_BANDS       = 10;
    localparam int DEF_GAIN_MAX      = 12;
    localparam int DEF_SETTLE_CYCLES = 8;

    typedef logic signed [15:0] gain_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE
    } state_t;

    function automatic gain_t clamp_gain(input gain_t g, input int lim);
        gain_t hi;
        gain_t lo;
        hi = gain_t'(lim);
        lo = -hi;
        if (g > hi) begin
            return hi;
        end else if (g < lo) begin
            return lo;
        end
        return g;
    endfunction

endpackage

// File: rtl/eq_band_scheduler_if.sv
// Request side and shared biquad gain bus of the band scheduler.
interface eq_band_scheduler_if
    import eq_pkg::*;
#(
    parameter int N_BANDS = DEF_N_BANDS,
    parameter int BAND_W  = $clog2(N_BANDS)
) ();

    logic               req_valid;
    logic               req_ready;
    logic [BAND_W-1:0]  req_band;
    gain_t              req_gain;
    logic               flat;
    logic [N_BANDS-1:0] set_pulse;
    gain_t              gain;
    logic               busy;
    logic               err;

    modport master (
        output req_valid, req_band, req_gain, flat,
        input  req_ready, set_pulse, gain, busy, err
    );

    modport slave (
        input  req_valid, req_band, req_gain, flat,
        output req_ready, set_pulse, gain, busy, err
    );

endinterface

// File: rtl/eq_band_scheduler_rr_pick.sv
// Round-robin pick of the next pending band, searching from last+1 with wrap.
module rr_pick #(
    parameter int N_BANDS = 10,
    parameter int BAND_W  = $clog2(N_BANDS)
) (
    input  logic [N_BANDS-1:0] mask,
    input  logic [BAND_W-1:0]  last,
    output logic [BAND_W-1:0]  sel,
    output logic               any
);

    int idx;

    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int i = 1; i <= N_BANDS; i++) begin
            idx = int'(last) + i;
            if (idx >= N_BANDS) begin
                idx = idx - N_BANDS;
            end
            if (!any && mask[idx]) begin
                any = 1'b1;
                sel = BAND_W'(idx);
            end
        end
    end

endmodule

// File: rtl/eq_band_scheduler.sv
// Holds per-band gains, coalesces writes, and issues one set pulse at a time
// to the biquad bank, holding off for a settle window after each pulse.
//
// state    | meaning
// S_IDLE   | waiting for a pending band; picks next one round-robin
// S_ISSUE  | one cycle: set pulse and gain word on the shared bus
// S_SETTLE | biquad computing coefficients; counter runs down to 0
module eq_band_scheduler
    import eq_pkg::*;
#(
    parameter int N_BANDS       = DEF_N_BANDS,
    parameter int GAIN_MAX      = DEF_GAIN_MAX,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int BAND_W        = $clog2(N_BANDS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    eq_band_scheduler_if.slave bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [BAND_W:0]   BAND_LIM  = (BAND_W + 1)'(N_BANDS);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(N_BANDS - 1);

    state_t             state;
    logic [BAND_W-1:0]  sel;
    logic [BAND_W-1:0]  last_band;
    logic [BAND_W-1:0]  pick_sel;
    logic               pick_any;
    logic [CNT_W-1:0]   cnt;
    gain_t              gain_tab [N_BANDS];
    gain_t              gain_nxt [N_BANDS];
    logic [N_BANDS-1:0] pending;
    logic [N_BANDS-1:0] pending_nxt;
    logic               accept;
    logic               band_ok;
    logic               wr_en;
    gain_t              wr_gain;

    // Flat owns the cycle it arrives in; any concurrent request is ignored.
    assign accept  = bus.req_valid & bus.req_ready & ~bus.flat;
    assign band_ok = {1'b0, bus.req_band} < BAND_LIM;
    assign wr_en   = accept & band_ok;
    assign wr_gain = clamp_gain(bus.req_gain, GAIN_MAX);

    // The issued band is cleared first so a same-cycle changing write re-arms it.
    always_comb begin
        pending_nxt = pending;
        for (int b = 0; b < N_BANDS; b++) begin
            gain_nxt[b] = gain_tab[b];
        end
        if (state == S_ISSUE) begin
            pending_nxt[sel] = 1'b0;
        end
        for (int b = 0; b < N_BANDS; b++) begin
            if (bus.flat) begin
                if (gain_tab[b] != '0) begin
                    gain_nxt[b]    = '0;
                    pending_nxt[b] = 1'b1;
                end
            end else if (wr_en && (bus.req_band == BAND_W'(b)) && (wr_gain != gain_tab[b])) begin
                gain_nxt[b]    = wr_gain;
                pending_nxt[b] = 1'b1;
            end
        end
    end

    rr_pick #(
        .N_BANDS (N_BANDS),
        .BAND_W  (BAND_W)
    ) u_rr_pick (
        .mask (pending),
        .last (last_band),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            sel           <= '0;
            last_band     <= BAND_LAST;
            cnt           <= '0;
            pending       <= '0;
            for (int b = 0; b < N_BANDS; b++) begin
                gain_tab[b] <= '0;
            end
            bus.req_ready <= 1'b0;
            bus.set_pulse <= '0;
            bus.gain      <= '0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            for (int b = 0; b < N_BANDS; b++) begin
                gain_tab[b] <= gain_nxt[b];
            end
            pending       <= pending_nxt;
            bus.req_ready <= ~bus.flat;
            bus.err       <= accept & ~band_ok;
            bus.set_pulse <= '0;
            bus.gain      <= '0;
            bus.busy      <= (state == S_ISSUE) || ((state == S_SETTLE) && (cnt != '0)) ||
                             (|pending_nxt);
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        sel           <= pick_sel;
                        state         <= S_ISSUE;
                        bus.set_pulse <= N_BANDS'(1) << pick_sel;
                        bus.gain      <= gain_nxt[pick_sel];
                    end
                end
                S_ISSUE: begin
                    last_band <= sel;
                    cnt       <= CNT_LOAD;
                    state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Bench for eq_band_scheduler: directed scenarios plus random traffic, every
// cycle compared against a table/timestamp reference model.
module tb_eq_band_scheduler;
    import eq_pkg::*;

    localparam int NB = 10;
    localparam int GM = 12;
    localparam int SC = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    eq_band_scheduler_if #(.N_BANDS(NB)) bus ();

    eq_band_scheduler #(
        .N_BANDS       (NB),
        .GAIN_MAX      (GM),
        .SETTLE_CYCLES (SC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: gain table, pending flags, and the edge index of the
    // last pulse; the next pulse is allowed SC+2 edges after the previous one.
    int      m_gain [NB];
    bit      m_pend [NB];
    int      m_last;
    int      t;
    int      free_at;
    int      lp;
    bit      lp_ok;
    int      iss;
    bit      m_ready;
    logic [NB-1:0] e_set;
    logic [15:0]   e_gain;
    bit      e_busy;
    bit      e_err;

    int log_band [$];
    int log_gain [$];
    int log_t    [$];

    function automatic int clampi(input int g);
        if (g > GM) return GM;
        if (g < -GM) return -GM;
        return g;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_gain[b] = 0;
            m_pend[b] = 1'b0;
        end
        m_last  = NB - 1;
        free_at = t;
        lp_ok   = 1'b0;
        iss     = -1;
        m_ready = 1'b0;
    endtask

    task automatic model_step(input bit v, input int band, input int g, input bit fl);
        bit acc;
        bit anyp;
        int nb;
        int c;
        t++;
        acc   = v && m_ready && !fl;
        e_err = acc && (band >= NB);
        if (iss >= 0) m_pend[iss] = 1'b0;
        anyp = 1'b0;
        for (int b = 0; b < NB; b++) anyp |= m_pend[b];
        nb = -1;
        if (t >= free_at && anyp) begin
            for (int k = 1; k <= NB; k++) begin
                if (nb < 0 && m_pend[(m_last + k) % NB]) nb = (m_last + k) % NB;
            end
            m_last  = nb;
            free_at = t + SC + 2;
            lp      = t;
            lp_ok   = 1'b1;
        end
        iss = nb;
        if (fl) begin
            for (int b = 0; b < NB; b++) begin
                if (m_gain[b] != 0) begin
                    m_gain[b] = 0;
                    m_pend[b] = 1'b1;
                end
            end
        end else if (acc && band < NB) begin
            c = clampi(g);
            if (c != m_gain[band]) begin
                m_gain[band] = c;
                m_pend[band] = 1'b1;
            end
        end
        e_set  = '0;
        e_gain = '0;
        if (nb >= 0) begin
            e_set[nb] = 1'b1;
            e_gain    = 16'(m_gain[nb]);
        end
        anyp = 1'b0;
        for (int b = 0; b < NB; b++) anyp |= m_pend[b];
        e_busy  = (lp_ok && t <= lp + SC) || anyp;
        m_ready = !fl;
    endtask

    task automatic cycle(input bit v, input int band, input int g, input bit fl);
        bus.req_valid = v;
        bus.req_band  = 4'(band);
        bus.req_gain  = 16'(g);
        bus.flat      = fl;
        @(posedge clk);
        model_step(v, band, g, fl);
        #1;
        chk("set",   32'(bus.set_pulse), 32'(e_set));
        chk("gain",  {16'b0, bus.gain}, {16'b0, e_gain});
        chk("busy",  32'(bus.busy), 32'(e_busy));
        chk("err",   32'(bus.err), 32'(e_err));
        chk("ready", 32'(bus.req_ready), 32'(m_ready));
        if (bus.set_pulse != '0) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.set_pulse[b]) log_band.push_back(b);
            end
            log_gain.push_back(int'($signed(bus.gain)));
            log_t.push_back(t);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!bus.busy) break;
            cycle(1'b0, 0, 0, 1'b0);
        end
        chk("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic clear_log();
        log_band.delete();
        log_gain.delete();
        log_t.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_set"},   32'(bus.set_pulse), 32'd0);
        chk({tag, "_gain"},  {16'b0, bus.gain}, 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_err"},   32'(bus.err), 32'd0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    int ta;
    int n_b2;
    int g_b2;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_band  = '0;
        bus.req_gain  = '0;
        bus.flat      = 1'b0;
        t = 0;
        #12;
        check_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // single write, latency and busy window
        clear_log();
        cycle(1'b1, 3, 6, 1'b0);
        ta = t;
        wait_idle();
        chk("t1_count", 32'(log_band.size()), 32'd1);
        if (log_band.size() >= 1) begin
            chk("t1_band", 32'(log_band[0]), 32'd3);
            chk("t1_gain", 32'(log_gain[0]), 32'd6);
            chk("t1_issue_edge", 32'(log_t[0] - ta), 32'd1);
            chk("t1_busy_drop", 32'(t - log_t[0]), 32'(SC + 1));
        end

        // clamping
        clear_log();
        cycle(1'b1, 0, 20, 1'b0);
        cycle(1'b1, 1, -30, 1'b0);
        wait_idle();
        chk("t2_count", 32'(log_band.size()), 32'd2);
        if (log_band.size() >= 2) begin
            chk("t2_gain0", 32'(log_gain[0]), 32'(12));
            chk("t2_gain1", 32'(log_gain[1]), 32'(-12));
        end

        // coalescing while the scheduler is busy with band 9
        clear_log();
        cycle(1'b1, 9, 3, 1'b0);
        cycle(1'b1, 2, 4, 1'b0);
        cycle(1'b1, 2, 5, 1'b0);
        wait_idle();
        n_b2 = 0;
        g_b2 = 0;
        foreach (log_band[i]) begin
            if (log_band[i] == 2) begin
                n_b2++;
                g_b2 = log_gain[i];
            end
        end
        chk("t3_b2_pulses", 32'(n_b2), 32'd1);
        chk("t3_b2_gain", 32'(g_b2), 32'd5);
        clear_log();
        cycle(1'b1, 2, 5, 1'b0);
        idle(12);
        chk("t3_repeat_none", 32'(log_band.size()), 32'd0);

        // round-robin order from last_band = 4
        cycle(1'b1, 4, 7, 1'b0);
        wait_idle();
        clear_log();
        for (int k = 0; k < NB; k++) cycle(1'b1, (5 + k) % NB, -(k + 1), 1'b0);
        wait_idle();
        chk("t4_count", 32'(log_band.size()), 32'(NB));
        if (log_band.size() == NB) begin
            for (int i = 0; i < NB; i++) begin
                chk("t4_order", 32'(log_band[i]), 32'((5 + i) % NB));
                if (i > 0) chk("t4_spacing", 32'(log_t[i] - log_t[i-1]), 32'(SC + 2));
            end
        end

        // flat
        cycle(1'b0, 0, 0, 1'b1);
        wait_idle();
        cycle(1'b1, 1, 5, 1'b0);
        cycle(1'b1, 7, -3, 1'b0);
        wait_idle();
        clear_log();
        cycle(1'b1, 4, 9, 1'b1);
        chk("t5_ready_low", 32'(bus.req_ready), 32'd0);
        wait_idle();
        chk("t5_count", 32'(log_band.size()), 32'd2);
        if (log_band.size() >= 2) begin
            chk("t5_band0", 32'(log_band[0]), 32'd1);
            chk("t5_band1", 32'(log_band[1]), 32'd7);
            chk("t5_gain0", 32'(log_gain[0]), 32'd0);
            chk("t5_gain1", 32'(log_gain[1]), 32'd0);
        end

        // out-of-range band
        clear_log();
        cycle(1'b1, 12, 4, 1'b0);
        chk("t6_err", 32'(bus.err), 32'd1);
        idle(3);
        chk("t6_no_set", 32'(log_band.size()), 32'd0);

        // reset in the middle of the settle window
        cycle(1'b1, 5, 9, 1'b0);
        idle(4);
        clear_log();
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("t7_abort");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(15);
        chk("t7_no_pulse", 32'(log_band.size()), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 2) == 0), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 40)) - 20, ($urandom_range(0, 80) == 0));
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
